// File: rtl/h264_pkg.sv
// Shared constants and enums for the macroblock loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package h264_pkg;

    localparam int MB_WORDS = 96;   // 64 Y + 16 U + 16 V words per 4:2:0 macroblock
    localparam int Y_WORDS  = 64;
    localparam int C_WORDS  = 16;
    localparam int MB_COLS  = 64;   // macroblocks per picture row

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PLANE_Y = 2'd0,
        PLANE_U = 2'd1,
        PLANE_V = 2'd2
    } plane_t;

endpackage

// File: rtl/h264_top_mb_unpack.sv
// Maps a macroblock word index to its plane, row and column base, and splits the word into bytes.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the word is stored.
// Ports: word_cnt (0..95), data_word in; plane, row, col_base, pix0..pix3 (pix0 = MSB byte) out.
module mb_unpack
    import h264_pkg::*;
(
    input  logic [6:0]  word_cnt,
    input  logic [31:0] data_word,
    output plane_t      plane,
    output logic [3:0]  row,
    output logic [3:0]  col_base,
    output logic [7:0]  pix0,
    output logic [7:0]  pix1,
    output logic [7:0]  pix2,
    output logic [7:0]  pix3
);

    always_comb begin
        plane    = PLANE_Y;
        row      = word_cnt[5:2];
        col_base = {word_cnt[1:0], 2'b00};
        // Chroma words are 64..79 (U) and 80..95 (V); in both ranges the
        // low four bits of the index are exactly the offset within the plane.
        if (word_cnt[6]) begin
            plane    = word_cnt[4] ? PLANE_V : PLANE_U;
            row      = {1'b0, word_cnt[3:1]};
            col_base = {1'b0, word_cnt[0], 2'b00};
        end
    end

    assign pix0 = data_word[31:24];
    assign pix1 = data_word[23:16];
    assign pix2 = data_word[15:8];
    assign pix3 = data_word[7:0];

endmodule

// File: rtl/h264_top.sv
// Macroblock loader: fetches 96 words of one 4:2:0 macroblock, unpacks into Y/U/V arrays, sums each plane.
// Latency: start sampled in IDLE -> 96 FETCH cycles (with data_valid=1) -> fetch_finish one cycle later.
// Backpressure: data_valid=0 stalls the fetch in place; start is only sampled in IDLE.
// Ports: clk, rst (sync, active high), start, data_valid, data_word in;
//        fetch_addr, fetch_finish, fetch_mb_x/y, y_sum, u_sum, v_sum out.
module h264_top
    import h264_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        data_valid,
    input  logic [31:0] data_word,
    output logic [31:0] fetch_addr,
    output logic        fetch_finish,
    output logic [5:0]  fetch_mb_x,
    output logic [5:0]  fetch_mb_y,
    output logic [15:0] y_sum,
    output logic [13:0] u_sum,
    output logic [13:0] v_sum
);

    state_t      state_q, state_d;
    logic [6:0]  word_cnt_q, word_cnt_d;
    logic [5:0]  mb_x_q, mb_x_d;
    logic [5:0]  mb_y_q, mb_y_d;
    logic [15:0] y_acc_q, y_acc_d, y_sum_q, y_sum_d;
    logic [13:0] u_acc_q, u_acc_d, u_sum_q, u_sum_d;
    logic [13:0] v_acc_q, v_acc_d, v_sum_q, v_sum_d;

    logic [7:0]  matrixY [0:15][0:15];
    logic [7:0]  matrixU [0:7][0:7];
    logic [7:0]  matrixV [0:7][0:7];

    plane_t      plane;
    logic [3:0]  row, col_base;
    logic [7:0]  pix0, pix1, pix2, pix3;
    logic [9:0]  word_sum;
    logic        store;

    mb_unpack u_unpack (
        .word_cnt  (word_cnt_q),
        .data_word (data_word),
        .plane     (plane),
        .row       (row),
        .col_base  (col_base),
        .pix0      (pix0),
        .pix1      (pix1),
        .pix2      (pix2),
        .pix3      (pix3)
    );

    assign word_sum = 10'(pix0) + 10'(pix1) + 10'(pix2) + 10'(pix3);
    assign store    = (state_q == FETCH) && data_valid && !rst;

    // Linear macroblock index is y*64 + x, i.e. a plain bit concatenation.
    assign fetch_addr   = {20'd0, mb_y_q, mb_x_q} * 32'(MB_WORDS) + {25'd0, word_cnt_q};
    assign fetch_finish = (state_q == DONE);
    assign fetch_mb_x   = mb_x_q;
    assign fetch_mb_y   = mb_y_q;
    assign y_sum        = y_sum_q;
    assign u_sum        = u_sum_q;
    assign v_sum        = v_sum_q;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        mb_x_d     = mb_x_q;
        mb_y_d     = mb_y_q;
        y_acc_d    = y_acc_q;
        u_acc_d    = u_acc_q;
        v_acc_d    = v_acc_q;
        y_sum_d    = y_sum_q;
        u_sum_d    = u_sum_q;
        v_sum_d    = v_sum_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FETCH;
                    word_cnt_d = 7'd0;
                    y_acc_d    = 16'd0;
                    u_acc_d    = 14'd0;
                    v_acc_d    = 14'd0;
                end
            end
            FETCH: begin
                if (data_valid) begin
                    word_cnt_d = word_cnt_q + 7'd1;
                    case (plane)
                        PLANE_Y: y_acc_d = y_acc_q + 16'(word_sum);
                        PLANE_U: u_acc_d = u_acc_q + 14'(word_sum);
                        default: v_acc_d = v_acc_q + 14'(word_sum);
                    endcase
                    // Publish sums including the final word so they are
                    // valid in the same cycle fetch_finish is high.
                    if (word_cnt_q == 7'(MB_WORDS - 1)) begin
                        state_d = DONE;
                        y_sum_d = y_acc_d;
                        u_sum_d = u_acc_d;
                        v_sum_d = v_acc_d;
                    end
                end
            end
            DONE: begin
                state_d    = IDLE;
                word_cnt_d = 7'd0;
                if (mb_x_q == 6'(MB_COLS - 1)) begin
                    mb_x_d = 6'd0;
                    mb_y_d = mb_y_q + 6'd1;
                end else begin
                    mb_x_d = mb_x_q + 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            word_cnt_q <= 7'd0;
            mb_x_q     <= 6'd0;
            mb_y_q     <= 6'd0;
            y_acc_q    <= 16'd0;
            u_acc_q    <= 14'd0;
            v_acc_q    <= 14'd0;
            y_sum_q    <= 16'd0;
            u_sum_q    <= 14'd0;
            v_sum_q    <= 14'd0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            mb_x_q     <= mb_x_d;
            mb_y_q     <= mb_y_d;
            y_acc_q    <= y_acc_d;
            u_acc_q    <= u_acc_d;
            v_acc_q    <= v_acc_d;
            y_sum_q    <= y_sum_d;
            u_sum_q    <= u_sum_d;
            v_sum_q    <= v_sum_d;
        end
    end

    // Pixel storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (store) begin
            case (plane)
                PLANE_Y: begin
                    matrixY[row][col_base]        <= pix0;
                    matrixY[row][col_base + 4'd1] <= pix1;
                    matrixY[row][col_base + 4'd2] <= pix2;
                    matrixY[row][col_base + 4'd3] <= pix3;
                end
                PLANE_U: begin
                    matrixU[row[2:0]][col_base[2:0]]        <= pix0;
                    matrixU[row[2:0]][col_base[2:0] + 3'd1] <= pix1;
                    matrixU[row[2:0]][col_base[2:0] + 3'd2] <= pix2;
                    matrixU[row[2:0]][col_base[2:0] + 3'd3] <= pix3;
                end
                default: begin
                    matrixV[row[2:0]][col_base[2:0]]        <= pix0;
                    matrixV[row[2:0]][col_base[2:0] + 3'd1] <= pix1;
                    matrixV[row[2:0]][col_base[2:0] + 3'd2] <= pix2;
                    matrixV[row[2:0]][col_base[2:0] + 3'd3] <= pix3;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_h264_top.sv
// Directed bench for the macroblock loader with a combinational word memory.
// Latency: n/a.
// Backpressure: data_valid driven directly by the stimulus.
module tb_h264_top;
    import h264_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, data_valid;
    logic [31:0] data_word, fetch_addr;
    logic        fetch_finish;
    logic [5:0]  fetch_mb_x, fetch_mb_y;
    logic [15:0] y_sum;
    logic [13:0] u_sum, v_sum;

    logic [31:0] mem [0:255];
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int c0, at, fin_cnt;

    h264_top dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .data_valid   (data_valid),
        .data_word    (data_word),
        .fetch_addr   (fetch_addr),
        .fetch_finish (fetch_finish),
        .fetch_mb_x   (fetch_mb_x),
        .fetch_mb_y   (fetch_mb_y),
        .y_sum        (y_sum),
        .u_sum        (u_sum),
        .v_sum        (v_sum)
    );

    always #5 clk = ~clk;

    always_comb data_word = (fetch_addr < 32'd256) ? mem[fetch_addr[7:0]] : 32'hDEAD_BEEF;

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        start = 1'b0;
        data_valid = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic fill_index;
        for (int i = 0; i < 256; i++) mem[i] = i;
    endtask

    // Returns the cycle number at which fetch_finish is seen, or -1 on timeout.
    task automatic wait_finish(input int budget, output int when);
        when = -1;
        for (int i = 0; i < budget; i++) begin
            if (fetch_finish) begin
                when = cyc;
                break;
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        data_valid = 1'b1;
        fill_index();

        // ---- reset state ----
        do_reset();
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("rst_addr", fetch_addr, 32'd0);
        chk("rst_finish", 32'(fetch_finish), 32'd0);
        chk("rst_mb_x", 32'(fetch_mb_x), 32'd0);
        chk("rst_mb_y", 32'(fetch_mb_y), 32'd0);
        chk("rst_y_sum", 32'(y_sum), 32'd0);

        // ---- address sequence, unpacking and sums on an index pattern ----
        mem[0]  = 32'h01020304;
        mem[64] = 32'hAABBCCDD;
        mem[95] = 32'h11223344;
        start = 1'b1;
        c0 = cyc;
        tick();
        start = 1'b0;
        fin_cnt = 0;
        for (int i = 0; i < 96; i++) begin
            chk("seq_addr", fetch_addr, 32'(i));
            if (fetch_finish) fin_cnt++;
            tick();
        end
        chk("seq_no_early_finish", 32'(fin_cnt), 32'd0);
        chk("seq_finish", 32'(fetch_finish), 32'd1);
        chk("seq_finish_cycle", 32'(cyc - c0), 32'd97);
        chk("seq_y_sum", 32'(y_sum), 32'd2026);
        chk("seq_u_sum", 32'(u_sum), 32'd1862);
        chk("seq_v_sum", 32'(v_sum), 32'd1475);
        tick();
        chk("seq_finish_pulse", 32'(fetch_finish), 32'd0);
        chk("seq_mb_x", 32'(fetch_mb_x), 32'd1);
        chk("y00", 32'(dut.matrixY[0][0]), 32'h01);
        chk("y01", 32'(dut.matrixY[0][1]), 32'h02);
        chk("y02", 32'(dut.matrixY[0][2]), 32'h03);
        chk("y03", 32'(dut.matrixY[0][3]), 32'h04);
        chk("y1515", 32'(dut.matrixY[15][15]), 32'h3F);
        chk("u00", 32'(dut.matrixU[0][0]), 32'hAA);
        chk("u03", 32'(dut.matrixU[0][3]), 32'hDD);
        chk("u77", 32'(dut.matrixU[7][7]), 32'h4F);
        chk("v74", 32'(dut.matrixV[7][4]), 32'h11);
        chk("v77", 32'(dut.matrixV[7][7]), 32'h44);

        // ---- maximum sums ----
        do_reset();
        for (int i = 0; i < 256; i++) mem[i] = 32'hFFFF_FFFF;
        start = 1'b1;
        c0 = cyc;
        tick();
        start = 1'b0;
        wait_finish(200, at);
        chk("max_finish_cycle", 32'(at - c0), 32'd97);
        chk("max_y_sum", 32'(y_sum), 32'd65280);
        chk("max_u_sum", 32'(u_sum), 32'd16320);
        chk("max_v_sum", 32'(v_sum), 32'd16320);

        // ---- stall at word 10 for 5 cycles ----
        do_reset();
        fill_index();
        start = 1'b1;
        c0 = cyc;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("stall_addr_pre", fetch_addr, 32'd10);
        data_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_addr_hold", fetch_addr, 32'd10);
            tick();
        end
        chk("stall_no_store", 32'(dut.matrixY[2][11]), 32'hFF);
        data_valid = 1'b1;
        chk("stall_addr_resume", fetch_addr, 32'd10);
        tick();
        chk("stall_store_after", 32'(dut.matrixY[2][11]), 32'h0A);
        wait_finish(200, at);
        chk("stall_finish_cycle", 32'(at - c0), 32'd102);

        // ---- start held across two macroblocks ----
        do_reset();
        start = 1'b1;
        c0 = cyc;
        tick();
        chk("b2b_first_addr", fetch_addr, 32'd0);
        for (int i = 0; i < 95; i++) tick();
        chk("b2b_last_addr0", fetch_addr, 32'd95);
        tick();
        chk("b2b_finish0", 32'(fetch_finish), 32'd1);
        chk("b2b_mb_x_done0", 32'(fetch_mb_x), 32'd0);
        tick();
        chk("b2b_mb_x1", 32'(fetch_mb_x), 32'd1);
        chk("b2b_idle_addr", fetch_addr, 32'd96);
        tick();
        chk("b2b_second_first", fetch_addr, 32'd96);
        for (int i = 0; i < 95; i++) tick();
        chk("b2b_second_last", fetch_addr, 32'd191);
        tick();
        chk("b2b_finish1", 32'(fetch_finish), 32'd1);
        chk("b2b_finish1_cycle", 32'(cyc - c0), 32'd195);
        start = 1'b0;
        tick();
        chk("b2b_mb_x2", 32'(fetch_mb_x), 32'd2);
        chk("b2b_y_sum_nonzero", 32'(y_sum != 16'd0), 32'd1);

        // ---- reset in the middle of a fetch (third macroblock, base 192) ----
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        chk("mid_addr", fetch_addr, 32'd232);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_state", 32'(dut.state_q), 32'(IDLE));
        chk("mid_addr_rst", fetch_addr, 32'd0);
        chk("mid_finish", 32'(fetch_finish), 32'd0);
        chk("mid_y_sum", 32'(y_sum), 32'd0);
        chk("mid_u_sum", 32'(u_sum), 32'd0);
        chk("mid_v_sum", 32'(v_sum), 32'd0);
        fin_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (fetch_finish) fin_cnt++;
            tick();
        end
        chk("mid_no_finish", 32'(fin_cnt), 32'd0);
        start = 1'b1;
        c0 = cyc;
        tick();
        start = 1'b0;
        chk("restart_addr", fetch_addr, 32'd0);
        wait_finish(200, at);
        chk("restart_finish_cycle", 32'(at - c0), 32'd97);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/h264_top.md
Name: h264_top

Overview:
- Macroblock loader at the front of the H.264 encoder datapath.
- On start, it fetches one 4:2:0 macroblock of 96 32-bit words over a word-addressed read port and unpacks it into three pixel arrays:
  - 16x16 luma (Y), words 0..63.
  - 8x8 Cb (U), words 64..79.
  - 8x8 Cr (V), words 80..95.
- It reports completion and running pixel sums for downstream stages and for verification.

Parameters:
- MB_WORDS, 96, words per macroblock (64 Y + 16 U + 16 V).
- MB_COLS, 64, macroblocks per row; fetch_mb_x wraps at this value.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level request; a fetch begins when sampled high in IDLE.
- data_valid  input  1  data_word holds valid data for the current fetch_addr.
- data_word  input  32  read data for fetch_addr, available in the same cycle (combinational memory).
- fetch_addr  output  32  word address = mb_index*MB_WORDS + word_cnt.
- fetch_finish  output  1  one-cycle pulse after the last word is stored.
- fetch_mb_x  output  6  column of the current or last macroblock.
- fetch_mb_y  output  6  row of the current or last macroblock.
- y_sum  output  16  sum of the 256 Y pixels of the last completed macroblock.
- u_sum  output  14  sum of the 64 U pixels of the last completed macroblock.
- v_sum  output  14  sum of the 64 V pixels of the last completed macroblock.
- All outputs other than the first six ports may be left unconnected by the instantiating level.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - fetch_addr, word_cnt, fetch_mb_x, fetch_mb_y, all sums and fetch_finish go to 0.
  - Pixel arrays are not cleared.
  - Reset mid-fetch abandons the macroblock; the sums keep their reset value 0.
- States: IDLE, FETCH, DONE.
  - IDLE: fetch_addr = mb_index*96. If start=1, go to FETCH with word_cnt=0.
  - FETCH: each cycle with data_valid=1, store data_word at word_cnt and increment word_cnt. fetch_addr tracks base+word_cnt combinationally from registers. data_valid=0 stalls: no store, no increment.
  - FETCH exit: when the word at word_cnt=95 is stored, go to DONE.
  - DONE (one cycle):
    - Assert fetch_finish.
    - Latch the accumulated y_sum, u_sum and v_sum to the outputs.
    - Advance the macroblock index: fetch_mb_x+1; on wrap at MB_COLS, fetch_mb_x=0 and fetch_mb_y+1 (6-bit wrap).
    - Go to IDLE.
  - Start sampling: start is sampled only in IDLE. If start is still high in IDLE, the next macroblock begins immediately. Start dropping during FETCH does not abort.
- Unpacking: byte 0 of a word is data_word[31:24], byte 3 is [7:0].
  - Y word w (0..63): row = w/4, columns 4*(w%4)+0..3.
  - U word w (64..79): k = w-64, row = k/2, columns 4*(k%2)+0..3.
  - V word w (80..95): same mapping as U with k = w-80.
- Arrays: internal arrays are named matrixY[0:15][0:15], matrixU[0:7][0:7] and matrixV[0:7][0:7], 8 bits per pixel, and are addressable hierarchically.
- Sums:
  - Accumulators clear when entering FETCH.
  - Each stored word adds its four bytes to the accumulator for its plane.
  - Widths are sized so no overflow occurs (max 65280 / 16320).
- Latency: with data_valid held at 1, start at cycle 0 gives:
  - FETCH cycles 1..96 reading addresses 0..95.
  - fetch_finish at cycle 97.

Decomposition:
- Package h264_pkg holds:
  - Constants: MB_WORDS=96, Y_WORDS=64, C_WORDS=16, MB_COLS.
  - State enum: IDLE/FETCH/DONE.
  - Plane-select enum: PLANE_Y/PLANE_U/PLANE_V.
- One sub-module, mb_unpack: takes word_cnt and data_word and outputs plane select, row, column base and four bytes.
- Top-level contains the FSM, the address counter, the arrays and the accumulators.

Test Plan:
- Reset then start=1 with mem[i]=i → fetch_addr goes 0,1,…,95 on consecutive cycles and fetch_finish pulses exactly once, 97 cycles after start.
- mem[0]=0x01020304 → matrixY[0][0..3] = 1,2,3,4. mem[64]=0xAABBCCDD → matrixU[0][0]=0xAA and matrixU[0][3]=0xDD. mem[95]=0x11223344 → matrixV[7][7]=0x44.
- All words 0xFFFFFFFF → y_sum=65280, u_sum=16320, v_sum=16320 at fetch_finish.
- Hold data_valid=0 for 5 cycles at word 10 → fetch_addr stays at 10, no store occurs, and finish is delayed by exactly 5 cycles.
- start held high across two macroblocks → second fetch reads addresses 96..191, fetch_mb_x=1 after the first finish and 2 after the second.
- Assert rst at word 40 → state is IDLE, fetch_addr=0, no fetch_finish, sums=0. A new start then fetches from address 0.
